// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and access-legality check for the data
// memory responder.
package mem_pkg;

    localparam logic [2:0] BHW_B  = 3'b000;
    localparam logic [2:0] BHW_H  = 3'b001;
    localparam logic [2:0] BHW_W  = 3'b010;
    localparam logic [2:0] BHW_BU = 3'b100;
    localparam logic [2:0] BHW_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // 1 when the width code is illegal or the byte address is not naturally aligned
    function automatic logic access_err(input logic [2:0] bhw, input logic [1:0] addr_lo);
        logic err_v;
        err_v = 1'b0;
        case (bhw)
            BHW_B, BHW_BU: err_v = 1'b0;
            BHW_H, BHW_HU: err_v = addr_lo[0];
            BHW_W:         err_v = (addr_lo != 2'b00);
            default:       err_v = 1'b1;
        endcase
        return err_v;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter: store merge with byte enables, load
// extraction with sign/zero extension, and the access error flag.
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [2:0]  bhw,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] wr_word,
    output logic [3:0]  byte_en,
    output logic [31:0] ld_val,
    output logic        err
);

    logic [31:0] wrep_s;
    logic [3:0]  be_raw_s;
    logic [31:0] ld_raw_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign err = access_err(bhw, addr_lo);

    // Lane selection of the old word for loads
    always_comb begin
        byte_s = old_word[7:0];
        case (addr_lo)
            2'b00:   byte_s = old_word[7:0];
            2'b01:   byte_s = old_word[15:8];
            2'b10:   byte_s = old_word[23:16];
            2'b11:   byte_s = old_word[31:24];
            default: byte_s = old_word[7:0];
        endcase
        half_s = addr_lo[1] ? old_word[31:16] : old_word[15:0];
    end

    // Width decode: raw enables, replicated store data and extended load value
    always_comb begin
        be_raw_s = 4'b0000;
        wrep_s   = wdata;
        ld_raw_s = 32'h0000_0000;
        case (bhw)
            BHW_B: begin
                be_raw_s = 4'b0001 << addr_lo;
                wrep_s   = {4{wdata[7:0]}};
                ld_raw_s = {{24{byte_s[7]}}, byte_s};
            end
            BHW_BU: begin
                be_raw_s = 4'b0001 << addr_lo;
                wrep_s   = {4{wdata[7:0]}};
                ld_raw_s = {24'h00_0000, byte_s};
            end
            BHW_H: begin
                be_raw_s = addr_lo[1] ? 4'b1100 : 4'b0011;
                wrep_s   = {2{wdata[15:0]}};
                ld_raw_s = {{16{half_s[15]}}, half_s};
            end
            BHW_HU: begin
                be_raw_s = addr_lo[1] ? 4'b1100 : 4'b0011;
                wrep_s   = {2{wdata[15:0]}};
                ld_raw_s = {16'h0000, half_s};
            end
            BHW_W: begin
                be_raw_s = 4'b1111;
                wrep_s   = wdata;
                ld_raw_s = old_word;
            end
            default: begin
                be_raw_s = 4'b0000;
                wrep_s   = wdata;
                ld_raw_s = 32'h0000_0000;
            end
        endcase
    end

    // An erroneous access must neither write nor return data
    assign byte_en = err ? 4'b0000 : be_raw_s;
    assign ld_val  = err ? 32'h0000_0000 : ld_raw_s;

    // Per-lane merge of new data into the old word
    always_comb begin
        wr_word = old_word;
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = byte_en[i] ? wrep_s[8*i +: 8] : old_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// Memory responder: single-outstanding load/store against a word RAM with a
// fixed response latency and a held response under back-pressure.
module data_mem_resp
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_bhw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);
    localparam bit         DIRECT   = (LATENCY == 1);

    state_e            state_r, state_nx_s;
    logic [3:0]        cnt_r, cnt_nx_s;
    logic              commit_s;
    logic              is_idle_s;

    logic              we_r;
    logic [2:0]        bhw_r;
    logic [ADDR_W+1:0] addr_r;
    logic [31:0]       wdata_r;

    logic              op_we_s;
    logic [2:0]        op_bhw_s;
    logic [ADDR_W+1:0] op_addr_s;
    logic [31:0]       op_wdata_s;

    logic [31:0]       mem_r [0:(1<<ADDR_W)-1];
    logic [31:0]       old_word_s, wr_word_s, ld_val_s;
    logic [3:0]        byte_en_s;
    logic              fmt_err_s;

    logic              req_ready_r, resp_valid_r, resp_err_r;
    logic [31:0]       resp_rdata_r;

    logic              unused_s;

    assign unused_s  = ^req_addr[31:ADDR_W+2];
    assign is_idle_s = (state_r == ST_IDLE);

    // With LATENCY=1 the access commits on the accept edge, so use live inputs
    assign op_we_s    = is_idle_s ? req_we                 : we_r;
    assign op_bhw_s   = is_idle_s ? req_bhw                : bhw_r;
    assign op_addr_s  = is_idle_s ? req_addr[ADDR_W+1:0]   : addr_r;
    assign op_wdata_s = is_idle_s ? req_wdata              : wdata_r;
    assign old_word_s = mem_r[op_addr_s[ADDR_W+1:2]];

    mem_lane_fmt u_fmt (
        .bhw      (op_bhw_s),
        .addr_lo  (op_addr_s[1:0]),
        .wdata    (op_wdata_s),
        .old_word (old_word_s),
        .wr_word  (wr_word_s),
        .byte_en  (byte_en_s),
        .ld_val   (ld_val_s),
        .err      (fmt_err_s)
    );

    // Next-state, latency counter and commit strobe
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        commit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (DIRECT) begin
                        state_nx_s = ST_RESP;
                        commit_s   = 1'b1;
                    end else begin
                        state_nx_s = ST_WAIT;
                        cnt_nx_s   = LAT_LOAD;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_nx_s = ST_RESP;
                    cnt_nx_s   = 4'd0;
                    commit_s   = 1'b1;
                end else begin
                    cnt_nx_s   = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 4'd0;
            end
        endcase
    end

    // State, counter and registered handshake/response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            req_ready_r  <= (state_nx_s == ST_IDLE);
            resp_valid_r <= (state_nx_s == ST_RESP);
            if (commit_s) begin
                resp_rdata_r <= (op_we_s || fmt_err_s) ? 32'h0000_0000 : ld_val_s;
                resp_err_r   <= fmt_err_s;
            end else if ((state_r == ST_RESP) && resp_ready) begin
                resp_rdata_r <= 32'h0000_0000;
                resp_err_r   <= 1'b0;
            end
        end
    end

    // Request capture on the acceptance edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            bhw_r   <= 3'b000;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
        end else if (is_idle_s && req_valid) begin
            we_r    <= req_we;
            bhw_r   <= req_bhw;
            addr_r  <= req_addr[ADDR_W+1:0];
            wdata_r <= req_wdata;
        end
    end

    // Storage array, deliberately not reset; errors arrive with no byte enables
    always_ff @(posedge clk) begin
        if (commit_s && op_we_s && (byte_en_s != 4'b0000)) begin
            mem_r[op_addr_s[ADDR_W+1:2]] <= wr_word_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed scoreboard bench for data_mem_resp: requests push expected
// responses; a negedge monitor pops and compares on every response handshake.
module tb_data_mem_resp;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_bhw = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_resp #(.ADDR_W(10), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_bhw    (req_bhw),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: one sample per response, on the cycle before its handshake edge
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got rdata %h err %b, expected none", resp_rdata, resp_err);
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            end
        end
    end

    // Issue one request, check its latency, and wait until its response is consumed
    task automatic issue(input logic we, input logic [2:0] bhw, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_er);
        int k;
        exp_q.push_back('{rdata: exp_rd, err: exp_er});
        @(negedge clk);
        req_we = we; req_bhw = bhw; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) begin n_tests++; n_fail++; $display("FAIL accept_timeout: got req_ready 0, expected 1"); end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b1; req_addr = 32'hFFFF_FFFC; req_wdata = 32'hA5A5_0F0F;
        // Accept at edge T: response visible in cycle T+LAT, i.e. LAT-1 edges later
        k = 0;
        while (!resp_valid && k < 50) begin @(posedge clk); #1; k++; end
        check("latency_edges", 32'(k), 32'(LAT - 1));
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL resp_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        rst_n = 1'b1;

        // Word store/load, then byte store into a cleared word
        issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 3'b010, 32'h0000_0010, 32'h0,        32'h0000_0000, 1'b0);
        issue(1'b1, 3'b000, 32'h0000_0013, 32'hFFFF_FF80, 32'h0000_0000, 1'b0);
        issue(1'b0, 3'b000, 32'h0000_0013, 32'h0,        32'hFFFF_FF80, 1'b0);
        issue(1'b0, 3'b100, 32'h0000_0013, 32'h0,        32'h0000_0080, 1'b0);
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'h8000_0000, 1'b0);

        // Halfword lanes, misaligned half load/store leave memory untouched
        issue(1'b1, 3'b010, 32'h0000_0020, 32'h0,        32'h0000_0000, 1'b0);
        issue(1'b1, 3'b001, 32'h0000_0022, 32'hABCD_1234, 32'h0000_0000, 1'b0);
        issue(1'b0, 3'b101, 32'h0000_0022, 32'h0,        32'h0000_1234, 1'b0);
        issue(1'b0, 3'b001, 32'h0000_0021, 32'h0,        32'h0000_0000, 1'b1);
        issue(1'b1, 3'b101, 32'h0000_0021, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        issue(1'b0, 3'b010, 32'h0000_0020, 32'h0,        32'h1234_0000, 1'b0);
        issue(1'b1, 3'b001, 32'h0000_0020, 32'h0000_8001, 32'h0000_0000, 1'b0);
        issue(1'b0, 3'b001, 32'h0000_0020, 32'h0,        32'hFFFF_8001, 1'b0);
        issue(1'b0, 3'b010, 32'h0000_0020, 32'h0,        32'h1234_8001, 1'b0);

        // Illegal codes, misaligned word, address wrap
        issue(1'b0, 3'b011, 32'h0000_0010, 32'h0,        32'h0000_0000, 1'b1);
        issue(1'b1, 3'b111, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        issue(1'b0, 3'b010, 32'h0000_0012, 32'h0,        32'h0000_0000, 1'b1);
        issue(1'b0, 3'b010, 32'h0000_1010, 32'h0,        32'h8000_0000, 1'b0);
        issue(1'b1, 3'b010, 32'h0000_1010, 32'h1122_3344, 32'h0000_0000, 1'b0);
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'h1122_3344, 1'b0);
        issue(1'b0, 3'b000, 32'h0000_0011, 32'h0,        32'h0000_0033, 1'b0);
        issue(1'b0, 3'b001, 32'h0000_0010, 32'h0,        32'h0000_3344, 1'b0);

        // Back-pressure: response held, new request ignored
        resp_ready = 1'b0;
        exp_q.push_back('{rdata: 32'h1122_3344, err: 1'b0});
        @(negedge clk);
        req_we = 1'b0; req_bhw = 3'b010; req_addr = 32'h0000_0010; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        begin
            int k;
            k = 0;
            while (!resp_valid && k < 50) begin @(posedge clk); #1; k++; end
            check("stall_latency_edges", 32'(k), 32'(LAT - 1));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
            check("stall_resp_rdata", resp_rdata, 32'h1122_3344);
            check("stall_req_ready", {31'b0, req_ready}, 32'd0);
            if (i == 1) begin
                req_we = 1'b1; req_bhw = 3'b010; req_addr = 32'h0000_0010;
                req_wdata = 32'hBAD0_BAD0; req_valid = 1'b1;
            end
            if (i == 3) req_valid = 1'b0;
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_req_ready", {31'b0, req_ready}, 32'd1);
        check("release_resp_valid", {31'b0, resp_valid}, 32'd0);
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'h1122_3344, 1'b0);

        // Reset during WAIT of a store: dropped, old value remains
        issue(1'b1, 3'b010, 32'h0000_0030, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0);
        @(negedge clk);
        req_we = 1'b1; req_bhw = 3'b010; req_addr = 32'h0000_0030; req_wdata = 32'h0000_0055; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("wait_req_ready", {31'b0, req_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req_ready", {31'b0, req_ready}, 32'd1);
        check("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("arst_resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 3'b010, 32'h0000_0030, 32'h0,        32'hA5A5_A5A5, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Responder end of the functional-unit memory interface: accepts one load/store request at a time from a memory FU over a valid/ready handshake and performs a byte/half/word access on an internal word-organised RAM. After a fixed, parameterised latency it returns a response (load data, sign- or zero-extended, or a store acknowledge) with an error flag for misaligned or illegal accesses. It sits between the memory FU and the data storage and replaces direct RAM instantiation inside the FU.

## Interface
- ADDR_W, 10: word-address width; the RAM holds 2^ADDR_W 32-bit words.
- LATENCY, 2: cycles from request acceptance to `resp_valid`; legal range 1..15.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder idle, request can be accepted
- req_we  in  1  1 = store, 0 = load
- req_bhw  in  3  width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal `req_bhw`

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch we/bhw/addr/wdata, load counter with LATENCY-1, go to WAIT (LATENCY=1 goes directly to RESP).
- WAIT: decrement counter; at 0 go to RESP; the access is performed on that transition edge.
- RESP: `resp_valid`=1, outputs stable until `resp_valid & resp_ready`, then IDLE.
- Word index = addr[ADDR_W+1:2]; higher address bits ignored (wrap).
- Error cases: bhw in {011,110,111}; H/HU with addr[0]=1; W with addr[1:0]≠0. On error: no RAM write, `resp_rdata`=0, `resp_err`=1.
- Store B: writes byte lane addr[1:0] with wdata[7:0]. Store H: writes lanes addr[1]*2 +{0,1} with wdata[15:0]. Store W: whole word. Other lanes unchanged. BU/HU with `req_we`=1 behave as B/H stores.
- Load: selects the lane(s), sign-extends for B/H, zero-extends for BU/HU; W is returned unmodified.
- RAM contents are not reset; state, counter and outputs are.

## Timing
- Reset: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, state IDLE.
- Accept at edge T (req_valid & req_ready sampled high) -> `resp_valid` high from cycle T+LATENCY. The store is visible to a load accepted after the response handshake.
- `req_ready` is 0 from T+1 until the cycle after the response handshake. Peak throughput is 1 request per LATENCY+1 cycles.
- `req_*` inputs are ignored outside the acceptance cycle. `resp_ready` is ignored outside RESP.
- Reset asserted mid-operation: the state returns to IDLE immediately. A store whose commit edge has not occurred is dropped. A store already committed stays in RAM.
- Back-pressure: the response holds indefinitely while `resp_ready`=0; no new request is accepted.

## Structure
- Package `mem_pkg`: bhw encodings (BHW_B, BHW_H, BHW_W, BHW_BU, BHW_HU), state enum, and a misalignment-check function.
- Sub-module `mem_lane_fmt` (combinational): from bhw, addr[1:0], wdata and the old word, produces the merged write word, byte enables, the extended load value and the error flag. The top holds the FSM, counter, latches and RAM.

## Test plan
- Reset then W store 0xDEADBEEF @0x10, LATENCY=2 -> resp_valid at T+2, rdata=0, err=0; W load @0x10 -> 0xDEADBEEF.
- B store 0x80 @0x13 over 0x00000000, then B load @0x13 -> 0xFFFFFF80; BU load -> 0x00000080; W load @0x10 -> 0x80000000.
- H store 0x1234 @0x22, HU load @0x22 -> 0x00001234; H load @0x21 -> err=1, rdata=0, memory unchanged.
- bhw=011 load -> err=1. Addr 0x00001010 with ADDR_W=10 aliases 0x10 (wrap).
- Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0, new req_valid ignored; release -> req_ready=1 next cycle.
- Assert rst_n low in WAIT during a store -> req_ready=1 and resp_valid=0 asynchronously; subsequent load of that address returns the old value.
